// File: rtl/gpio_uart_pkg.sv
// Shared definitions for the GPIO-to-UART bridge.
//   uart_state_t         : TX framing FSM states
//   UART_DATA_ADDR       : default data register address (byte writes are queued)
//   UART_CTRL_ADDR       : default control register address (a write clears overflow)
//   DEFAULT_CLKS_PER_BIT : 50 MHz clock / 115200 baud
package gpio_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [31:0] UART_DATA_ADDR       = 32'h0000_4000;
   localparam logic [31:0] UART_CTRL_ADDR       = UART_DATA_ADDR + 32'd1;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/gpio_uart_bridge_fifo.sv
// sync_fifo: single-clock FIFO that holds the bytes waiting for the UART.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-low reset (empties the FIFO)
//   push  in  write request, din captured at the edge
//   din   in  WIDTH-bit write data
//   pop   in  read request, dout is consumed at the edge
//   dout  out head entry (combinational read of the registered read pointer)
//   full  out count == DEPTH
//   empty out count == 0
//   count out entries held, $clog2(DEPTH)+1 bits
//
// Handshake: a pop is honoured whenever the FIFO is non-empty. A push is
// honoured when the FIFO is not full, or when it is full and an honoured pop
// frees the head slot in the same cycle; otherwise the push is discarded.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly AW bits so they wrap at DEPTH (a power of two).
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gpio_uart_bridge.sv
// gpio_uart_bridge: turns processor GPIO byte writes into UART 8N1 output.
//   clk        in  rising-edge clock
//   rst        in  synchronous active-low reset
//   GPIOaddr   in  32-bit write address
//   GPIO       in  write data byte
//   GPIOEn     in  write strobe, one write per cycle
//   tx         out UART serial line, idles high, registered
//   busy       out frame in flight or bytes buffered, registered
//   overflow   out sticky, a data write was dropped on a full FIFO
//   fifo_count out bytes buffered
//   dbg_state  out current TX FSM state
//
// A write to BASE_ADDR queues GPIO; a write to BASE_ADDR+1 clears overflow.
module gpio_uart_bridge
   import gpio_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [31:0] BASE_ADDR    = UART_DATA_ADDR
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   GPIOaddr,
   input  logic [7:0]                    GPIO,
   input  logic                          GPIOEn,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output uart_state_t                   dbg_state
);

   localparam int unsigned        BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [31:0]        CTRL_ADDR = BASE_ADDR + 32'd1;

   uart_state_t       state, state_n;
   logic [BAUD_W-1:0] baud_cnt, baud_n;
   logic [2:0]        bit_idx, bit_n;
   logic [7:0]        shift, shift_n;
   logic              tx_n;
   logic              busy_n;

   logic              data_wr;
   logic              ctrl_wr;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_dout;

   assign data_wr   = GPIOEn && (GPIOaddr == BASE_ADDR);
   assign ctrl_wr   = GPIOEn && (GPIOaddr == CTRL_ADDR);
   assign dbg_state = state;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_wr),
      .din   (GPIO),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A write is only lost when the FIFO is full and no pop frees a slot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (ctrl_wr) begin
         overflow <= 1'b0;
      end else if (data_wr && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end
   end

   // The FSM only ever looks at the registered FIFO state, so a byte written at
   // edge E is popped at E+1 and tx (registered from state) falls at E+2.
   always_comb begin
      state_n  = state;
      baud_n   = baud_cnt;
      bit_n    = bit_idx;
      shift_n  = shift;
      fifo_pop = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_n  = fifo_dout;
               baud_n   = '0;
               state_n  = START;
            end
         end
         START: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = 3'd0;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               state_n = IDLE;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Line level and busy are derived from the current state and registered,
   // which puts both one cycle behind the state register.
   always_comb begin
      case (state)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift[0];
         default: tx_n = 1'b1;
      endcase
      busy_n = (state != IDLE) || (fifo_count != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
         tx       <= tx_n;
         busy     <= busy_n;
      end
   end

endmodule

// File: tb/tb_gpio_uart_bridge.sv
// Directed bench for gpio_uart_bridge with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_gpio_uart_bridge;
   import gpio_uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] gpio_addr = 32'h0;
   logic [7:0]  gpio_data = 8'h00;
   logic        gpio_en = 1'b0;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [2:0]  fifo_count;
   uart_state_t dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gpio_uart_bridge #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .BASE_ADDR    (32'h0000_4000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .GPIOaddr   (gpio_addr),
      .GPIO       (gpio_data),
      .GPIOEn     (gpio_en),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count),
      .dbg_state  (dbg_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus write, captured at the next rising edge.
   task automatic wr(input logic [31:0] addr, input logic [7:0] data);
      gpio_addr = addr;
      gpio_data = data;
      gpio_en   = 1'b1;
      step();
      gpio_en   = 1'b0;
   endtask

   // Check a whole 8N1 frame cycle by cycle. skip > 0 means the frame is
   // already that many cycles old; skip == 0 waits (bounded) for the start bit.
   task automatic check_frame(input logic [7:0] d, input int skip);
      logic [9:0] fr;
      int waited;
      fr = {1'b1, d, 1'b0};
      waited = 0;
      if (skip == 0) begin
         while (tx !== 1'b0 && waited < 100) begin
            step();
            waited++;
         end
         check($sformatf("frame_%02h_start", d), tx, 32'd0);
      end
      for (int k = skip; k < 10*CPB; k++) begin
         check($sformatf("frame_%02h_tx_k%0d", d, k), tx, fr[k/CPB]);
         check($sformatf("frame_%02h_busy_k%0d", d, k), busy, 32'd1);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      rst = 1'b0;
      step();
      step();
      check("rst_tx", tx, 32'd1);
      check("rst_busy", busy, 32'd0);
      check("rst_overflow", overflow, 32'd0);
      check("rst_count", fifo_count, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b1;
      step();

      // 1: single byte A5, latency and busy timing
      wr(32'h4000, 8'hA5);                      // edge E
      check("t1_count_e", fifo_count, 32'd1);
      check("t1_tx_e", tx, 32'd1);
      step();                                   // E+1: popped
      check("t1_count_e1", fifo_count, 32'd0);
      check("t1_busy_e1", busy, 32'd1);
      check("t1_tx_e1", tx, 32'd1);
      check("t1_state_e1", 32'(dbg_state), 32'(START));
      step();                                   // E+2: start bit
      check("t1_tx_e2", tx, 32'd0);
      check_frame(8'hA5, 0);                    // samples E+2..E+41
      check("t1_busy_e42", busy, 32'd0);
      check("t1_tx_e42", tx, 32'd1);

      // 2: back-to-back writes; the first byte leaves one cycle after it
      // lands, so six writes are needed to overfill a depth-4 FIFO
      wr(32'h4000, 8'h01);                      // E1
      wr(32'h4000, 8'h02);                      // E2: 01 popped
      wr(32'h4000, 8'h03);
      wr(32'h4000, 8'h04);
      wr(32'h4000, 8'h05);                      // E5: full
      check("t2_count_full", fifo_count, 32'd4);
      check("t2_overflow_pre", overflow, 32'd0);
      wr(32'h4000, 8'h06);                      // E6: dropped
      check("t2_count_drop", fifo_count, 32'd4);
      check("t2_overflow", overflow, 32'd1);
      check_frame(8'h01, 3);                    // start bit began at E3
      check_frame(8'h02, 0);
      check_frame(8'h03, 0);
      check_frame(8'h04, 0);
      check_frame(8'h05, 0);
      check("t2_count_end", fifo_count, 32'd0);
      check("t2_busy_end", busy, 32'd0);
      check("t2_overflow_sticky", overflow, 32'd1);

      // 3: control write clears overflow, queues nothing
      wr(32'h4001, 8'h00);
      check("t3_overflow", overflow, 32'd0);
      check("t3_count", fifo_count, 32'd0);
      step();
      step();
      check("t3_tx", tx, 32'd1);
      check("t3_busy", busy, 32'd0);

      // 4: neighbouring addresses are ignored
      wr(32'h4002, 8'hFF);
      check("t4_count_a", fifo_count, 32'd0);
      wr(32'h3FFF, 8'hFF);
      check("t4_count_b", fifo_count, 32'd0);
      step();
      step();
      check("t4_tx", tx, 32'd1);
      check("t4_busy", busy, 32'd0);
      check("t4_overflow", overflow, 32'd0);

      // 5: reset during data bit 3 of 3C with two bytes queued
      wr(32'h4000, 8'h3C);                      // E
      wr(32'h4000, 8'h11);                      // E+1
      wr(32'h4000, 8'h22);                      // E+2
      check("t5_count_q", fifo_count, 32'd2);
      for (int i = 0; i < 16; i++) step();      // E+18: bit 3 on tx
      check("t5_state_data", 32'(dbg_state), 32'(DATA));
      check("t5_tx_bit3", tx, 32'd1);
      check("t5_busy_pre", busy, 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("t5_tx_rst", tx, 32'd1);
      check("t5_count_rst", fifo_count, 32'd0);
      check("t5_busy_rst", busy, 32'd0);
      check("t5_state_rst", 32'(dbg_state), 32'(IDLE));
      for (int i = 0; i < 60; i++) begin
         step();
         check($sformatf("t5_tx_quiet_%0d", i), tx, 32'd1);
      end
      check("t5_busy_end", busy, 32'd0);
      check("t5_count_end", fifo_count, 32'd0);

      // 6: push while full in the same cycle the FSM pops
      wr(32'h4000, 8'h10);                      // E: popped at E+1
      wr(32'h4000, 8'h20);
      wr(32'h4000, 8'h30);
      wr(32'h4000, 8'h40);
      wr(32'h4000, 8'h50);                      // E+4: full
      for (int i = 0; i < 37; i++) step();      // E+41: STOP done
      check("t6_state_idle", 32'(dbg_state), 32'(IDLE));
      check("t6_count_full", fifo_count, 32'd4);
      wr(32'h4000, 8'h77);                      // E+42: push + pop
      check("t6_count_same", fifo_count, 32'd4);
      check("t6_overflow", overflow, 32'd0);
      check("t6_state_start", 32'(dbg_state), 32'(START));
      check_frame(8'h20, 0);
      check_frame(8'h30, 0);
      check_frame(8'h40, 0);
      check_frame(8'h50, 0);
      check_frame(8'h77, 0);
      check("t6_count_end", fifo_count, 32'd0);
      check("t6_busy_end", busy, 32'd0);
      check("t6_overflow_end", overflow, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
